// File: rtl/hier_icache_pkg.sv
// Shared constants and types for the hierarchical I-cache control unit:
// register map, FSM states and response opcodes.
package hier_icache_pkg;

  localparam logic [5:0] IDX_ENABLE_ICACHE   = 6'h00;
  localparam logic [5:0] IDX_FLUSH_ICACHE    = 6'h01;
  localparam logic [5:0] IDX_FLUSH_L1_ONLY   = 6'h02;
  localparam logic [5:0] IDX_SEL_FLUSH       = 6'h03;
  localparam logic [5:0] IDX_CLEAR_CNTS      = 6'h04;
  localparam logic [5:0] IDX_ENABLE_CNTS     = 6'h05;
  localparam logic [5:0] IDX_ENABLE_PREFETCH = 6'h07;

  localparam int unsigned STAT_BASE_IDX = 8;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH_WAIT,
    ST_SEL_FLUSH_WAIT,
    ST_RESP
  } ctrl_state_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        opc;
  } resp_t;

endpackage

// File: rtl/hier_icache_stat_cnt.sv
// Per-core hit/miss event counter pair; clear has priority over counting.
module hier_icache_stat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             hit_i,
  input  logic             miss_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  logic [CNT_W-1:0] hit_q, miss_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (clr_i) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (en_i) begin
      if (hit_i)  hit_q  <= hit_q + 1'b1;
      if (miss_i) miss_q <= miss_q + 1'b1;
    end
  end

  assign hit_cnt_o  = hit_q;
  assign miss_cnt_o = miss_q;

endmodule

// File: rtl/hier_icache_ctrl_unit.sv
// Peripheral-mapped control for the hierarchical I-cache: enables, flush
// handshakes and optional per-core hit/miss counters (HIER_ICACHE_STAT_EN).
module hier_icache_ctrl_unit
  import hier_icache_pkg::*;
#(
  parameter int NB_CORES = 8,
  parameter int ID_WIDTH = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                speriph_req_i,
  output logic                speriph_gnt_o,
  input  logic                speriph_wen_i,
  input  logic [31:0]         speriph_add_i,
  input  logic [31:0]         speriph_wdata_i,
  input  logic [ID_WIDTH-1:0] speriph_id_i,
  output logic                speriph_r_valid_o,
  output logic [31:0]         speriph_r_rdata_o,
  output logic [ID_WIDTH-1:0] speriph_r_id_o,
  output logic                speriph_r_opc_o,
  output logic                icache_enable_o,
  output logic                prefetch_en_o,
  output logic                flush_req_o,
  output logic                flush_l1_only_o,
  input  logic                flush_ack_i,
  output logic                sel_flush_req_o,
  output logic [31:0]         sel_flush_addr_o,
  input  logic                sel_flush_ack_i,
  input  logic [NB_CORES-1:0] hit_evt_i,
  input  logic [NB_CORES-1:0] miss_evt_i
);

  ctrl_state_e state_q, state_d;
  resp_t               resp_q;
  logic [ID_WIDTH-1:0] resp_id_q;
  logic                icache_en_q, prefetch_q, flush_req_q, l1_only_q, sel_req_q;
  logic [31:0]         sel_addr_q;

  logic [5:0]  idx;
  logic        req_acc, wr_acc, is_cnt, cnt_clr, cnt_en_rd, dec_err;
  logic [31:0] cnt_rdata, dec_rdata;
  logic        unused_add;

  assign idx        = speriph_add_i[7:2];
  assign unused_add = ^{speriph_add_i[31:8], speriph_add_i[1:0]};
  assign req_acc    = speriph_req_i && (state_q == ST_IDLE);
  assign wr_acc     = req_acc && !speriph_wen_i;
  assign cnt_clr    = wr_acc && (idx == IDX_CLEAR_CNTS);
  assign is_cnt     = (idx >= 6'(STAT_BASE_IDX)) && (idx < 6'(STAT_BASE_IDX + 2 * NB_CORES));

`ifdef HIER_ICACHE_STAT_EN
  logic                          cnt_en_q;
  logic [5:0]                    cnt_off;
  logic [NB_CORES-1:0][31:0]     hit_cnt, miss_cnt;

  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    hier_icache_stat_cnt #(.CNT_W(32)) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (cnt_en_q),
      .clr_i      (cnt_clr),
      .hit_i      (hit_evt_i[c]),
      .miss_i     (miss_evt_i[c]),
      .hit_cnt_o  (hit_cnt[c]),
      .miss_cnt_o (miss_cnt[c])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                cnt_en_q <= 1'b0;
    else if (wr_acc && idx == IDX_ENABLE_CNTS)  cnt_en_q <= speriph_wdata_i[0];
  end

  // Even offsets are hit counters, odd offsets miss counters.
  assign cnt_off = idx - 6'(STAT_BASE_IDX);
  always_comb begin
    cnt_rdata = '0;
    for (int c = 0; c < NB_CORES; c++)
      if (cnt_off[5:1] == 5'(c)) cnt_rdata = cnt_off[0] ? miss_cnt[c] : hit_cnt[c];
  end
  assign cnt_en_rd = cnt_en_q;
`else
  logic unused_evt;
  assign unused_evt = ^{hit_evt_i, miss_evt_i, cnt_clr};
  assign cnt_rdata  = '0;
  assign cnt_en_rd  = 1'b0;
`endif

  always_comb begin
    dec_rdata = '0;
    dec_err   = RESP_OK;
    case (idx)
      IDX_ENABLE_ICACHE:   dec_rdata = {31'b0, icache_en_q};
      IDX_FLUSH_ICACHE,
      IDX_FLUSH_L1_ONLY,
      IDX_CLEAR_CNTS:      dec_rdata = '0;
      IDX_SEL_FLUSH:       dec_rdata = sel_addr_q;
      IDX_ENABLE_CNTS:     dec_rdata = {31'b0, cnt_en_rd};
      IDX_ENABLE_PREFETCH: dec_rdata = {31'b0, prefetch_q};
      default: begin
        if (is_cnt) dec_rdata = cnt_rdata;
        else        dec_err   = RESP_ERR;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_acc && (idx == IDX_FLUSH_ICACHE || idx == IDX_FLUSH_L1_ONLY))
          state_d = ST_FLUSH_WAIT;
        else if (wr_acc && idx == IDX_SEL_FLUSH)
          state_d = ST_SEL_FLUSH_WAIT;
        else if (req_acc)
          state_d = ST_RESP;
      end
      ST_FLUSH_WAIT:     if (flush_ack_i)     state_d = ST_RESP;
      ST_SEL_FLUSH_WAIT: if (sel_flush_ack_i) state_d = ST_RESP;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    speriph_gnt_o     = 1'b0;
    speriph_r_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: speriph_gnt_o     = speriph_req_i;
      ST_RESP: speriph_r_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q      <= '0;
      resp_id_q   <= '0;
      icache_en_q <= 1'b0;
      prefetch_q  <= 1'b0;
      flush_req_q <= 1'b0;
      l1_only_q   <= 1'b0;
      sel_req_q   <= 1'b0;
      sel_addr_q  <= '0;
    end else begin
      if (req_acc) begin
        resp_id_q    <= speriph_id_i;
        resp_q.rdata <= speriph_wen_i ? dec_rdata : '0;
        resp_q.opc   <= dec_err;
      end
      if (wr_acc) begin
        case (idx)
          IDX_ENABLE_ICACHE:   icache_en_q <= speriph_wdata_i[0];
          IDX_ENABLE_PREFETCH: prefetch_q  <= speriph_wdata_i[0];
          IDX_FLUSH_ICACHE:    begin flush_req_q <= 1'b1; l1_only_q <= 1'b0; end
          IDX_FLUSH_L1_ONLY:   begin flush_req_q <= 1'b1; l1_only_q <= 1'b1; end
          IDX_SEL_FLUSH:       begin sel_req_q <= 1'b1; sel_addr_q <= speriph_wdata_i; end
          default: ;
        endcase
      end
      if (state_q == ST_FLUSH_WAIT && flush_ack_i) begin
        flush_req_q <= 1'b0;
        l1_only_q   <= 1'b0;
      end
      if (state_q == ST_SEL_FLUSH_WAIT && sel_flush_ack_i) sel_req_q <= 1'b0;
    end
  end

  assign speriph_r_rdata_o = speriph_r_valid_o ? resp_q.rdata : '0;
  assign speriph_r_opc_o   = speriph_r_valid_o ? resp_q.opc   : 1'b0;
  assign speriph_r_id_o    = speriph_r_valid_o ? resp_id_q    : '0;
  assign icache_enable_o   = icache_en_q;
  assign prefetch_en_o     = prefetch_q;
  assign flush_req_o       = flush_req_q;
  assign flush_l1_only_o   = l1_only_q;
  assign sel_flush_req_o   = sel_req_q;
  assign sel_flush_addr_o  = sel_addr_q;

endmodule

// File: tb/tb_hier_icache_ctrl_unit.sv
// Scoreboard bench for hier_icache_ctrl_unit plus a narrow counter instance
// exercising the wrap/clear behaviour of hier_icache_stat_cnt.
module tb_hier_icache_ctrl_unit;

`ifdef HIER_ICACHE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        opc;
    logic [4:0]  id;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, gnt, wen = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [4:0]  id = '0;
  logic        r_valid, r_opc;
  logic [31:0] r_rdata;
  logic [4:0]  r_id;
  logic        ic_en, pf_en, fl_req, fl_l1, fl_ack = 1'b0;
  logic        sf_req, sf_ack = 1'b0;
  logic [31:0] sf_addr;
  logic [7:0]  hit_evt = '0, miss_evt = '0;

  logic        c_en = 1'b0, c_clr = 1'b0, c_hit = 1'b0, c_miss = 1'b0;
  logic [3:0]  c_hcnt, c_mcnt;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, rv_seen = 0;

  always #5 clk = ~clk;

  hier_icache_ctrl_unit #(.NB_CORES(8), .ID_WIDTH(5)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .speriph_req_i(req), .speriph_gnt_o(gnt), .speriph_wen_i(wen),
    .speriph_add_i(addr), .speriph_wdata_i(wdata), .speriph_id_i(id),
    .speriph_r_valid_o(r_valid), .speriph_r_rdata_o(r_rdata),
    .speriph_r_id_o(r_id), .speriph_r_opc_o(r_opc),
    .icache_enable_o(ic_en), .prefetch_en_o(pf_en),
    .flush_req_o(fl_req), .flush_l1_only_o(fl_l1), .flush_ack_i(fl_ack),
    .sel_flush_req_o(sf_req), .sel_flush_addr_o(sf_addr), .sel_flush_ack_i(sf_ack),
    .hit_evt_i(hit_evt), .miss_evt_i(miss_evt)
  );

  hier_icache_stat_cnt #(.CNT_W(4)) u_cnt4 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(c_en), .clr_i(c_clr),
    .hit_i(c_hit), .miss_i(c_miss), .hit_cnt_o(c_hcnt), .miss_cnt_o(c_mcnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && r_valid) begin
      rv_seen++;
      if (sb.size() == 0) chk("unexp_rvalid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("r_rdata", r_rdata, e.rdata);
        chk("r_opc", {31'b0, r_opc}, {31'b0, e.opc});
        chk("r_id", {27'b0, r_id}, {27'b0, e.id});
      end
    end
  end

  // Issues one request; returns #1 after the grant edge.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] i, input logic [31:0] erd, input logic eopc,
                        input logic [7:0] hev);
    exp_t e;
    @(posedge clk); #1;
    req = 1'b1; wen = w; addr = a; wdata = d; id = i; hit_evt = hev;
    e.rdata = erd; e.opc = eopc; e.id = i;
    sb.push_back(e);
    @(negedge clk);
    chk("gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; hit_evt = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    chk("resp_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("reset_outs", {26'b0, gnt, r_valid, ic_en, pf_en, fl_req, sf_req}, 32'd0);
    chk("reset_sel_addr", sf_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_req(1'b0, 32'h00, 32'd1, 5'd3, 32'd0, 1'b0, 8'h0);
    chk("icache_en_next", {31'b0, ic_en}, 32'd1);
    drain();
    do_req(1'b1, 32'h00, 32'd0, 5'd4, 32'd1, 1'b0, 8'h0);
    do_req(1'b0, 32'h1C, 32'd1, 5'd5, 32'd0, 1'b0, 8'h0);
    do_req(1'b1, 32'h1C, 32'd0, 5'd6, 32'd1, 1'b0, 8'h0);
    drain();
    chk("prefetch_en", {31'b0, pf_en}, 32'd1);

    // L1-only flush, ack after five cycles, with a competing request held.
    do_req(1'b0, 32'h08, 32'd0, 5'd7, 32'd0, 1'b0, 8'h0);
    req = 1'b1; wen = 1'b1; addr = 32'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("l1_flush_req", {29'b0, fl_req, fl_l1, gnt}, 32'b110);
      if (i == 4) fl_ack = 1'b1;
    end
    @(posedge clk); #1 fl_ack = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("l1_flush_done", {30'b0, fl_req, r_valid}, 32'b01);
    drain();

    // Full flush; a selective-flush ack during the wait must be ignored.
    do_req(1'b0, 32'h04, 32'd0, 5'd8, 32'd0, 1'b0, 8'h0);
    sf_ack = 1'b1;
    @(posedge clk); #1 sf_ack = 1'b0;
    @(negedge clk);
    chk("full_flush_req", {30'b0, fl_req, fl_l1}, 32'b10);
    fl_ack = 1'b1;
    @(posedge clk); #1 fl_ack = 1'b0;
    drain();
    chk("full_flush_drop", {31'b0, fl_req}, 32'd0);

    // Stray ack while idle, then selective flush.
    fl_ack = 1'b1; sf_ack = 1'b1;
    @(posedge clk); #1 fl_ack = 1'b0; sf_ack = 1'b0;
    do_req(1'b0, 32'h0C, 32'h1C000040, 5'd9, 32'd0, 1'b0, 8'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sel_req_held", {31'b0, sf_req}, 32'd1);
      chk("sel_addr", sf_addr, 32'h1C000040);
    end
    sf_ack = 1'b1;
    @(posedge clk); #1 sf_ack = 1'b0;
    drain();
    chk("sel_req_drop", {31'b0, sf_req}, 32'd0);
    do_req(1'b1, 32'h0C, 32'd0, 5'd10, 32'h1C000040, 1'b0, 8'h0);

    // Unmapped accesses.
    do_req(1'b1, 32'hFC, 32'd0, 5'd11, 32'd0, 1'b1, 8'h0);
    do_req(1'b0, 32'h18, 32'd0, 5'd12, 32'd0, 1'b1, 8'h0);
    drain();
    chk("unmapped_no_effect", {30'b0, ic_en, pf_en}, 32'b11);

    // Counters.
    do_req(1'b0, 32'h14, 32'd1, 5'd13, 32'd0, 1'b0, 8'h0);
    drain();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 hit_evt = 8'h04;
      @(posedge clk); #1 hit_evt = 8'h00;
    end
    @(posedge clk); #1 miss_evt = 8'h04;
    @(posedge clk); #1 miss_evt = 8'h00;
    do_req(1'b1, 32'h14, 32'd0, 5'd14, {31'b0, STAT}, 1'b0, 8'h0);
    do_req(1'b1, 32'h30, 32'd0, 5'd15, STAT ? 32'd3 : 32'd0, 1'b0, 8'h0);
    do_req(1'b1, 32'h34, 32'd0, 5'd16, STAT ? 32'd1 : 32'd0, 1'b0, 8'h0);
    do_req(1'b1, 32'h20, 32'd0, 5'd17, 32'd0, 1'b0, 8'h0);
    do_req(1'b0, 32'h10, 32'd0, 5'd18, 32'd0, 1'b0, 8'h04);
    do_req(1'b1, 32'h30, 32'd0, 5'd19, 32'd0, 1'b0, 8'h0);
    drain();

    // Narrow counter: wrap and clear priority.
    @(posedge clk); #1 c_en = 1'b1; c_hit = 1'b1;
    repeat (15) @(posedge clk);
    #1 c_hit = 1'b0;
    chk("cnt4_full", {28'b0, c_hcnt}, 32'd15);
    c_hit = 1'b1;
    @(posedge clk); #1 c_hit = 1'b0;
    chk("cnt4_wrap", {28'b0, c_hcnt}, 32'd0);
    c_miss = 1'b1;
    @(posedge clk); #1 c_miss = 1'b0; c_hit = 1'b1; c_clr = 1'b1;
    chk("cnt4_miss", {28'b0, c_mcnt}, 32'd1);
    @(posedge clk); #1 c_hit = 1'b0; c_clr = 1'b0;
    chk("cnt4_clr_wins", {24'b0, c_hcnt, c_mcnt}, 32'd0);
    c_en = 1'b0; c_hit = 1'b1;
    @(posedge clk); #1 c_hit = 1'b0;
    chk("cnt4_disabled", {28'b0, c_hcnt}, 32'd0);

    // Reset during flush wait abandons the transaction.
    do_req(1'b0, 32'h04, 32'd0, 5'd20, 32'd0, 1'b0, 8'h0);
    @(negedge clk);
    chk("rst_pre_flush", {31'b0, fl_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_flush_drop", {29'b0, fl_req, ic_en, pf_en}, 32'd0);
    sb.delete();
    rv_seen = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_rvalid_after_rst", rv_seen, 32'd0);
    do_req(1'b1, 32'h00, 32'd0, 5'd21, 32'd0, 1'b0, 8'h0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hier_icache_ctrl_unit.md
HIER_ICACHE_CTRL_UNIT -- requirements
Module: hier_icache_ctrl_unit

Interface
REQ-001 SHALL have parameter NB_CORES, default 8, number of cores with hit/miss event inputs (1..8).
REQ-002 SHALL have parameter ID_WIDTH, default 5, width of the peripheral transaction ID.
REQ-003 SHALL have port clk_i  in  1  sole clock.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports speriph_req_i in 1, speriph_gnt_o out 1, speriph_wen_i in 1 (1=read), speriph_add_i in 32, speriph_wdata_i in 32, speriph_id_i in ID_WIDTH: config request.
REQ-006 SHALL have ports speriph_r_valid_o out 1, speriph_r_rdata_o out 32, speriph_r_id_o out ID_WIDTH, speriph_r_opc_o out 1 (1=error): response.
REQ-007 SHALL have ports icache_enable_o out 1, prefetch_en_o out 1: cache mode.
REQ-008 SHALL have ports flush_req_o out 1, flush_l1_only_o out 1, flush_ack_i in 1: full/L1 flush handshake.
REQ-009 SHALL have ports sel_flush_req_o out 1, sel_flush_addr_o out 32, sel_flush_ack_i in 1: selective flush handshake.
REQ-010 SHALL have ports hit_evt_i in NB_CORES, miss_evt_i in NB_CORES: per-core one-cycle event pulses.

Function
REQ-011 SHALL decode register index speriph_add_i[7:2] against ENABLE_ICACHE (0x00), FLUSH_ICACHE (0x04), FLUSH_L1_ONLY (0x08), SEL_FLUSH_ICACHE (0x0C), CLEAR_CNTS (0x10), ENABLE_CNTS (0x14), ENABLE_L1_L15_PREFETCH (0x1C).
REQ-012 SHALL place counters from index 8: hit counter of core c at index 8+2c, miss counter at 9+2c, read-only.
REQ-013 SHALL run FSM states IDLE, FLUSH_WAIT, SEL_FLUSH_WAIT, RESP; speriph_gnt_o = speriph_req_i only in IDLE, else 0.
REQ-014 SHALL, on granted write to ENABLE_ICACHE / ENABLE_L1_L15_PREFETCH / ENABLE_CNTS, latch wdata[0] into the matching bit that cycle, go to RESP.
REQ-015 SHALL, on granted write to FLUSH_ICACHE or FLUSH_L1_ONLY, assert flush_req_o next cycle with flush_l1_only_o=1 only for FLUSH_L1_ONLY, go to FLUSH_WAIT.
REQ-016 SHALL, on granted write to SEL_FLUSH_ICACHE, register wdata into sel_flush_addr_o, assert sel_flush_req_o next cycle, go to SEL_FLUSH_WAIT.
REQ-017 SHALL hold req and address stable in *_WAIT until the ack is sampled high; drop req the cycle after; go to RESP.
REQ-018 SHALL, in RESP, pulse speriph_r_valid_o for exactly one cycle with the latched ID, then return to IDLE; write response rdata = 0.
REQ-019 SHALL answer reads one cycle after grant (via RESP) with register value zero-extended; counters full 32 bits.
REQ-020 SHALL answer unmapped index (read or write) with r_opc_o=1, rdata=0, no side effect.
REQ-021 SHALL, when cnt_en=1, increment each counter on its event; 32-bit wrap 0xFFFF_FFFF -> 0.
REQ-022 SHALL, on granted write to CLEAR_CNTS, zero all counters; clear wins over same-cycle increment.
REQ-023 SHALL ignore an ack arriving outside the matching *_WAIT state.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously force IDLE, all outputs 0, sel_flush_addr_o 0, counters 0, icache_enable_o 0, prefetch_en_o 0, cnt_en 0; a pending flush is abandoned without response.

Configuration
REQ-025 SHALL compile per-core counters only with HIER_ICACHE_STAT_EN defined; without it counter reads return 0 with r_opc_o=0, CLEAR_CNTS/ENABLE_CNTS writes accepted with no effect, event inputs ignored.

Structure
REQ-026 SHALL place register-index constants, STAT_BASE_IDX (8), the FSM state enum and response opcode constants in hier_icache_pkg.
REQ-027 SHALL instantiate sub-module hier_icache_stat_cnt per core (hit/miss pair with enable and clear).

Verification
REQ-028 SHALL: write 1 to 0x00 -> icache_enable_o=1 next cycle, r_valid one cycle later, r_opc=0.
REQ-029 SHALL: write 0x08, ack after 5 cycles -> flush_req_o=1 and flush_l1_only_o=1 for 5 cycles, gnt=0 throughout, r_valid 1 cycle after ack.
REQ-030 SHALL: write 0x1C000040 to 0x0C -> sel_flush_addr_o=0x1C000040 with req held until ack.
REQ-031 SHALL: enable counters, 3 hit pulses core 2, read index 12 -> 3; CLEAR_CNTS same cycle as hit -> 0.
REQ-032 SHALL: counter preloaded to 0xFFFFFFFF plus one hit -> 0; read index 0x3F -> r_opc=1, rdata=0.
REQ-033 SHALL: rst_ni low during FLUSH_WAIT -> flush_req_o=0 immediately, no r_valid after release.
